// File: rtl/fruit_pkg.sv
// Shared constants and types for the fruit scheduler: screen bounds,
// velocity limits, LFSR seed/taps and the frame-update FSM states.
package fruit_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Largest on-screen coordinates, in storage and signed-intermediate forms
  localparam logic [9:0]        X_MAX   = 10'(SCREEN_W - 1);
  localparam logic [9:0]        Y_MAX   = 10'(SCREEN_H - 1);
  localparam logic signed [10:0] X_LIMIT = 11'(SCREEN_W - 1);
  localparam logic signed [10:0] Y_LIMIT = 11'(SCREEN_H - 1);

  // Velocities are 5-bit signed; gravity saturates vy at VY_MAX
  localparam logic signed [4:0] VY_MAX        = 5'sd15;
  localparam logic signed [4:0] VX_SPAWN      = 5'sd2;
  localparam logic [4:0]        VY_SPAWN_BASE = 5'd12;
  localparam logic [9:0]        SPAWN_X_OFS   = 10'd32;

  localparam logic [9:0] SCORE_MAX  = 10'd999;
  localparam logic [1:0] MISSES_MAX = 2'd3;

  // Fibonacci LFSR, taps 16,14,13,11 -> state bits 15,13,12,10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_SPAWN  = 2'd2
  } fsm_state_e;

  // One shift of the LFSR: new bit enters at the bottom
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/fruit_scheduler_if.sv
// Frame/blade inputs and slot/score outputs of the fruit scheduler.
interface fruit_scheduler_if #(
  parameter int NUM_SLOTS = 4
);
  logic                   frame_tick;
  logic                   game_en;
  logic [9:0]             blade_x;
  logic [9:0]             blade_y;
  logic                   blade_valid;
  logic [NUM_SLOTS-1:0]   slot_active;
  logic [10*NUM_SLOTS-1:0] slot_x;
  logic [10*NUM_SLOTS-1:0] slot_y;
  logic [9:0]             score;
  logic [1:0]             misses;
  logic                   game_over;
  logic                   busy;
  logic                   overrun;

  modport master (
    output frame_tick, game_en, blade_x, blade_y, blade_valid,
    input  slot_active, slot_x, slot_y, score, misses, game_over, busy, overrun
  );

  modport slave (
    input  frame_tick, game_en, blade_x, blade_y, blade_valid,
    output slot_active, slot_x, slot_y, score, misses, game_over, busy, overrun
  );
endinterface

// File: rtl/fruit_lfsr.sv
// Free-running 16-bit Fibonacci LFSR used as the spawn randomness source.
// It never stalls, so spawn values depend on elapsed clocks, not on game_en.
module fruit_lfsr
  import fruit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] lfsr
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR value
  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  // LFSR state register, reseeded on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/fruit_scheduler.sv
// Fruit slot scheduler: on each accepted frame tick, walks every slot once
// (slice check, motion, off-screen check) and then makes one spawn attempt.
module fruit_scheduler
  import fruit_pkg::*;
#(
  parameter int NUM_SLOTS    = 4,
  parameter int SPAWN_PERIOD = 60,
  parameter int HIT_RADIUS   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  fruit_scheduler_if.slave bus
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
  localparam logic [IDX_W-1:0] IDX_ZERO   = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_SLOTS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SPAWN_PERIOD - 1);
  localparam logic signed [10:0] HIT_R    = 11'(HIT_RADIUS);

  fsm_state_e              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_SLOTS-1:0]    act_q, act_d;
  logic [9:0]              x_q  [NUM_SLOTS];
  logic [9:0]              x_d  [NUM_SLOTS];
  logic [9:0]              y_q  [NUM_SLOTS];
  logic [9:0]              y_d  [NUM_SLOTS];
  logic signed [4:0]       vx_q [NUM_SLOTS];
  logic signed [4:0]       vx_d [NUM_SLOTS];
  logic signed [4:0]       vy_q [NUM_SLOTS];
  logic signed [4:0]       vy_d [NUM_SLOTS];
  logic [9:0]              score_q, score_d;
  logic [1:0]              misses_q, misses_d;
  logic                    overrun_q, overrun_d;

  logic [15:0]             lfsr;
  logic                    lfsr_unused;
  logic                    game_over;
  logic                    start;
  logic                    found;

  // Working values for the slot addressed by idx_q
  logic [9:0]              cur_x, cur_y, clamp_x, spawn_x;
  logic signed [4:0]       cur_vx, cur_vy, nvy, spawn_vx, spawn_vy;
  logic signed [10:0]      dx, dy, adx, ady, nx, ny;
  logic                    hit, fell;

  fruit_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .lfsr  (lfsr)
  );

  assign lfsr_unused = ^lfsr[15:12];
  assign game_over   = (misses_q == MISSES_MAX);
  assign start       = bus.frame_tick && bus.game_en && !game_over;

  // Slice test, motion and spawn values for the slot under update
  always_comb begin
    cur_x  = x_q[idx_q];
    cur_y  = y_q[idx_q];
    cur_vx = vx_q[idx_q];
    cur_vy = vy_q[idx_q];

    // Slice test uses the position before this frame's motion
    dx  = $signed({1'b0, bus.blade_x}) - $signed({1'b0, cur_x});
    dy  = $signed({1'b0, bus.blade_y}) - $signed({1'b0, cur_y});
    adx = dx[10] ? (11'sd0 - dx) : dx;
    ady = dy[10] ? (11'sd0 - dy) : dy;
    hit = bus.blade_valid && (adx < HIT_R) && (ady < HIT_R);

    nx  = $signed({1'b0, cur_x}) + $signed({{6{cur_vx[4]}}, cur_vx});
    ny  = $signed({1'b0, cur_y}) + $signed({{6{cur_vy[4]}}, cur_vy});
    nvy = (cur_vy >= VY_MAX) ? VY_MAX : (cur_vy + 5'sd1);

    if (nx < 11'sd0) begin
      clamp_x = 10'd0;
    end else if (nx > X_LIMIT) begin
      clamp_x = X_MAX;
    end else begin
      clamp_x = nx[9:0];
    end

    // Off-screen only counts once the fruit is on its way down
    fell = (ny > Y_LIMIT) && (nvy > 5'sd0);

    spawn_x  = {1'b0, lfsr[8:0]} + SPAWN_X_OFS;
    spawn_vy = 5'sd0 - $signed({3'b000, lfsr[10:9]} + VY_SPAWN_BASE);
    spawn_vx = lfsr[11] ? VX_SPAWN : (5'sd0 - VX_SPAWN);
  end

  // Frame-update FSM: next state and all slot/score updates
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    act_d     = act_q;
    x_d       = x_q;
    y_d       = y_q;
    vx_d      = vx_q;
    vy_d      = vy_q;
    score_d   = score_q;
    misses_d  = misses_q;
    found     = 1'b0;
    overrun_d = overrun_q | (bus.frame_tick && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_UPDATE;
          idx_d   = IDX_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_UPDATE: begin
        if (act_q[idx_q] && (hit || fell)) begin
          act_d[idx_q] = 1'b0;
          x_d[idx_q]   = 10'd0;
          y_d[idx_q]   = 10'd0;
          vx_d[idx_q]  = 5'sd0;
          vy_d[idx_q]  = 5'sd0;
          if (hit) begin
            score_d = (score_q < SCORE_MAX) ? (score_q + 10'd1) : score_q;
          end else begin
            misses_d = (misses_q < MISSES_MAX) ? (misses_q + 2'd1) : misses_q;
          end
        end else if (act_q[idx_q]) begin
          x_d[idx_q]  = clamp_x;
          y_d[idx_q]  = ny[9:0];
          vy_d[idx_q] = nvy;
        end else begin
          act_d[idx_q] = 1'b0;
        end

        if (idx_q == IDX_LAST) begin
          state_d = ST_SPAWN;
          idx_d   = IDX_ZERO;
        end else begin
          idx_d = idx_q + IDX_ONE;
        end
      end

      ST_SPAWN: begin
        state_d = ST_IDLE;
        if (cnt_q == CNT_ZERO) begin
          cnt_d = CNT_RELOAD;
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!found && !act_q[i]) begin
              found    = 1'b1;
              act_d[i] = 1'b1;
              x_d[i]   = spawn_x;
              y_d[i]   = Y_MAX;
              vx_d[i]  = spawn_vx;
              vy_d[i]  = spawn_vy;
            end else begin
              found = found;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = IDX_ZERO;
      end
    endcase
  end

  // State, slot and score registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= IDX_ZERO;
      cnt_q     <= CNT_RELOAD;
      act_q     <= {NUM_SLOTS{1'b0}};
      score_q   <= 10'd0;
      misses_q  <= 2'd0;
      overrun_q <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i]  <= 10'd0;
        y_q[i]  <= 10'd0;
        vx_q[i] <= 5'sd0;
        vy_q[i] <= 5'sd0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      score_q   <= score_d;
      misses_q  <= misses_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i]  <= x_d[i];
        y_q[i]  <= y_d[i];
        vx_q[i] <= vx_d[i];
        vy_q[i] <= vy_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign bus.slot_x[10*g +: 10] = x_q[g];
    assign bus.slot_y[10*g +: 10] = y_q[g];
  end

  assign bus.slot_active = act_q;
  assign bus.score       = score_q;
  assign bus.misses      = misses_q;
  assign bus.game_over   = game_over;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_fruit_scheduler.sv
// Randomized bench for fruit_scheduler with a frame-level reference model.
module tb_fruit_scheduler;

  localparam int NS = 4;
  localparam int SP = 60;
  localparam int HR = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fruit_scheduler_if #(.NUM_SLOTS(NS)) bus ();
  fruit_scheduler_if #(.NUM_SLOTS(NS)) bus2 ();

  fruit_scheduler #(.NUM_SLOTS(NS), .SPAWN_PERIOD(SP), .HIT_RADIUS(HR)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Second instance spawns every frame so all slots can fill up
  fruit_scheduler #(.NUM_SLOTS(NS), .SPAWN_PERIOD(1), .HIT_RADIUS(HR)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state (frame level)
  int   m_act [NS];
  int   m_x   [NS];
  int   m_y   [NS];
  int   m_vx  [NS];
  int   m_vy  [NS];
  int   m_score, m_misses, m_cnt;
  bit   m_overrun;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference LFSR: reseeded by reset, one step per clock
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_clear(input int i);
    m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) model_clear(i);
    m_score = 0; m_misses = 0; m_cnt = SP - 1; m_overrun = 1'b0;
  endtask

  // One full frame: every slot in order, then one spawn attempt
  task automatic model_frame(input logic [15:0] lf, input bit bv, input int bx, input int by);
    logic [15:0] sl;
    int nx;
    for (int i = 0; i < NS; i++) begin
      if (m_act[i] != 0) begin
        if (bv && iabs(bx - m_x[i]) < HR && iabs(by - m_y[i]) < HR) begin
          model_clear(i);
          if (m_score < 999) m_score++;
        end else begin
          nx = m_x[i] + m_vx[i];
          m_y[i] = m_y[i] + m_vy[i];
          m_vy[i] = (m_vy[i] < 15) ? m_vy[i] + 1 : 15;
          m_x[i] = (nx < 0) ? 0 : ((nx > 639) ? 639 : nx);
          if (m_y[i] > 479 && m_vy[i] > 0) begin
            model_clear(i);
            if (m_misses < 3) m_misses++;
          end
        end
      end
    end
    // Spawn happens NS+1 clocks after the tick is taken
    sl = lf;
    for (int k = 0; k < NS + 1; k++) sl = lfsr_step(sl);
    if (m_cnt == 0) begin
      m_cnt = SP - 1;
      for (int i = 0; i < NS; i++) begin
        if (m_act[i] == 0) begin
          m_act[i] = 1;
          m_x[i]   = int'(sl[8:0]) + 32;
          m_y[i]   = 479;
          m_vy[i]  = -(12 + int'(sl[10:9]));
          m_vx[i]  = sl[11] ? 2 : -2;
          break;
        end
      end
    end else begin
      m_cnt--;
    end
  endtask

  task automatic check_state(input string p);
    logic [NS-1:0]    e_act;
    logic [10*NS-1:0] e_x, e_y;
    for (int i = 0; i < NS; i++) begin
      e_act[i]       = (m_act[i] != 0);
      e_x[10*i +: 10] = 10'(m_x[i]);
      e_y[10*i +: 10] = 10'(m_y[i]);
    end
    chk($sformatf("%s_active", p), bus.slot_active, e_act);
    chk($sformatf("%s_x", p), bus.slot_x, e_x);
    chk($sformatf("%s_y", p), bus.slot_y, e_y);
    chk($sformatf("%s_score", p), bus.score, m_score);
    chk($sformatf("%s_misses", p), bus.misses, m_misses);
    chk($sformatf("%s_game_over", p), bus.game_over, (m_misses == 3));
    chk($sformatf("%s_overrun", p), bus.overrun, m_overrun);
    chk($sformatf("%s_busy", p), bus.busy, 0);
  endtask

  // Pulse one tick, optionally a second tick mid-sequence or a game_en drop
  task automatic do_frame(input bit en, input bit bv, input int bx, input int by,
                          input bit dbl, input bit drop);
    logic [15:0] lf;
    int bcnt;
    bit run;
    @(negedge clk);
    bus.game_en     = en;
    bus.blade_valid = bv;
    bus.blade_x     = 10'(bx);
    bus.blade_y     = 10'(by);
    bus.frame_tick  = 1'b1;
    lf  = m_lfsr;
    run = en && (m_misses < 3);
    if (run) model_frame(lf, bv, bx, by);
    bcnt = 0;
    for (int c = 0; c < NS + 3; c++) begin
      @(negedge clk);
      bus.frame_tick = dbl && (c == 1);
      if (drop && c == 1) bus.game_en = 1'b0;
      if (dbl && c == 1 && run) m_overrun = 1'b1;
      if (bus.busy) bcnt++;
    end
    bus.blade_valid = 1'b0;
    chk("busy_cycles", bcnt, run ? NS + 1 : 0);
    check_state("frame");
  endtask

  initial begin
    logic [3:0] exp2;
    int bx, by, j;
    bit bv;
    bus.frame_tick = 1'b0; bus.game_en = 1'b1; bus.blade_valid = 1'b0;
    bus.blade_x = 10'd0; bus.blade_y = 10'd0;
    bus2.frame_tick = 1'b0; bus2.game_en = 1'b1; bus2.blade_valid = 1'b0;
    bus2.blade_x = 10'd0; bus2.blade_y = 10'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Every-frame spawner: fills all slots, then the 5th and 6th spawns are skipped
    exp2 = 4'b0000;
    for (int f = 0; f < 6; f++) begin
      @(negedge clk); bus2.frame_tick = 1'b1;
      @(negedge clk); bus2.frame_tick = 1'b0;
      repeat (NS + 2) @(negedge clk);
      exp2 = {exp2[2:0], 1'b1};
      chk($sformatf("full_slots_f%0d", f), bus2.slot_active, exp2);
    end

    // First spawn lands on the SP-th frame in slot 0 and does not move yet
    for (int f = 0; f < SP - 1; f++) do_frame(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("no_spawn_early", bus.slot_active, 4'b0000);
    do_frame(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("spawn_slot0", bus.slot_active, 4'b0001);
    chk("spawn_y", bus.slot_y[9:0], 10'd479);
    chk("spawn_x_range", (bus.slot_x[9:0] >= 10'd32) && (bus.slot_x[9:0] <= 10'd543), 1);

    // Blade right on the fruit: slice, no miss
    do_frame(1'b1, 1'b1, m_x[0], m_y[0], 1'b0, 1'b0);
    chk("slice_cleared", bus.slot_active[0], 0);
    chk("slice_score", bus.score, 1);
    chk("slice_misses", bus.misses, 0);

    // Next spawn, then let it fly off the bottom; one overrun along the way
    for (int f = 0; f < SP - 1; f++) do_frame(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("respawn", bus.slot_active, 4'b0001);
    for (int f = 0; f < 40; f++) do_frame(1'b1, 1'b0, 0, 0, (f == 5), 1'b0);
    chk("miss_count", bus.misses, 1);
    chk("miss_cleared", bus.slot_active, 4'b0000);
    chk("overrun_sticky", bus.overrun, 1);

    // Random play: aimed and stray blades, pauses, overruns, game_en drops
    for (int f = 0; f < 300; f++) begin
      bv = ($urandom_range(0, 1) == 1);
      bx = $urandom_range(0, 639);
      by = $urandom_range(0, 479);
      j  = $urandom_range(0, NS - 1);
      if (bv && m_act[j] != 0 && $urandom_range(0, 1) == 1) begin
        bx = m_x[j] + int'($urandom_range(0, 40)) - 20;
        by = m_y[j] + int'($urandom_range(0, 40)) - 20;
        bx = (bx < 0) ? 0 : ((bx > 1023) ? 1023 : bx);
        by = (by < 0) ? 0 : ((by > 1023) ? 1023 : by);
      end
      do_frame(($urandom_range(0, 9) != 0), bv, bx, by,
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    // Run to game over, then ticks must not move anything
    for (int f = 0; f < 600 && m_misses < 3; f++) do_frame(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    chk("game_over", bus.game_over, 1);
    for (int f = 0; f < 3; f++) do_frame(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

    // Reset clears everything
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_state("reset_after_over");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a sequence, then a clean sequence
    @(negedge clk); bus.game_en = 1'b1; bus.frame_tick = 1'b1;
    @(negedge clk); bus.frame_tick = 1'b0;
    @(negedge clk);
    chk("mid_seq_busy", bus.busy, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_state("reset_mid_seq");
    @(negedge clk);
    rst_n = 1'b1;
    do_frame(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fruit_scheduler.md
FRUIT_SCHEDULER -- requirements
Module: fruit_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of fruit object slots.
REQ-002 SHALL have parameter SPAWN_PERIOD, default 60, frames between spawn attempts.
REQ-003 SHALL have parameter HIT_RADIUS, default 16, slice half-window in pixels.
REQ-004 Clk  input  1  system clock; single clock domain.
REQ-005 Reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 frame_tick  input  1  one-cycle pulse at start of vertical blank.
REQ-007 game_en  input  1  1 = play; 0 = freeze all state except LFSR.
REQ-008 blade_x, blade_y  input  10 each  blade pixel position, unsigned.
REQ-009 blade_valid  input  1  blade is cutting this frame.
REQ-010 slot_active  output  NUM_SLOTS  per-slot occupied flag.
REQ-011 slot_x, slot_y  output  10*NUM_SLOTS each  flat packed positions; slot i at bits [10i+9:10i].
REQ-012 score  output  10  slices, binary, saturating at 999.
REQ-013 misses  output  2  fruits lost off-screen, saturating at 3.
REQ-014 game_over  output  1  high when misses == 3.
REQ-015 busy  output  1  high while the frame update sequence runs.
REQ-016 overrun  output  1  sticky; a frame_tick arrived while busy.

Function
REQ-017 SHALL run a 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1, advancing every clock, including when game_en = 0.
REQ-018 FSM states: IDLE, UPDATE, SPAWN; IDLE->UPDATE on frame_tick with game_en = 1 and game_over = 0; UPDATE visits slots 0..NUM_SLOTS-1, one per cycle; UPDATE->SPAWN after last slot; SPAWN->IDLE after one cycle.
REQ-019 busy SHALL be 1 in UPDATE and SPAWN; sequence latency NUM_SLOTS+1 cycles after the tick.
REQ-020 frame_tick while busy SHALL be ignored and SHALL set overrun.
REQ-021 For an active slot in UPDATE: x += vx, y += vy (signed, 11-bit intermediate); then vy += 1, saturating at +15.
REQ-022 Slice check in UPDATE on pre-update position: blade_valid and |blade_x-x| < HIT_RADIUS and |blade_y-y| < HIT_RADIUS -> slot cleared, score += 1 (saturating), no motion applied.
REQ-023 Miss: post-update y > 479 with vy > 0 -> slot cleared, misses += 1 (saturating); slice takes priority over miss in the same cycle.
REQ-024 x leaving 0..639 SHALL clamp to 0 or 639; vx unchanged.
REQ-025 Spawn counter decrements once per completed sequence; in SPAWN with counter == 0, the lowest-index free slot SHALL load x = LFSR[8:0]+32, y = 479, vy = -(12+LFSR[10:9]), vx = LFSR[11] ? +2 : -2; counter SHALL reload SPAWN_PERIOD-1.
REQ-026 No free slot at spawn time: spawn skipped, counter still reloads.
REQ-027 A slot spawned in SPAWN SHALL NOT move until the next frame.
REQ-028 game_en falling mid-sequence SHALL let the current sequence complete.

Reset
REQ-029 Reset_n low SHALL asynchronously force: FSM IDLE, all slots inactive, positions and velocities 0, score 0, misses 0, overrun 0, busy 0, spawn counter SPAWN_PERIOD-1, LFSR 16'hACE1.
REQ-030 Reset mid-sequence SHALL abandon it; first tick after release starts a clean sequence.

Structure
REQ-031 Shared package fruit_pkg SHALL hold the screen bounds (640, 480), the velocity limits, LFSR seed/taps and the FSM state enum.
REQ-032 A single sub-module fruit_lfsr SHALL implement REQ-017; slot state SHALL be register arrays in fruit_scheduler.

Verification
REQ-033 Reset, then SPAWN_PERIOD ticks -> exactly one spawn, slot 0 active, y = 479, x in 32..543.
REQ-034 Spawned fruit, no blade, 40 ticks -> rises, falls, cleared when y > 479; misses = 1.
REQ-035 Blade at fruit (x,y) with blade_valid on next tick -> slot cleared at that sequence, score = 1, misses unchanged.
REQ-036 All 4 slots active at spawn time -> no spawn, counter reloads 59, slot_active stays 4'b1111.
REQ-037 frame_tick pulsed 2 cycles after a prior tick -> second ignored, overrun = 1, positions advance once.
REQ-038 misses reaching 3 -> game_over = 1; further ticks produce no motion; Reset_n low clears all outputs to REQ-029 values.
